// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 mux stage and every producer of its select code.
package mux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The mux decodes channel 3 as 2'b00 and channel 0 as 2'b11.
  function automatic logic [1:0] ch2sel(input logic [1:0] ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first requesting channel at or after ptr.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic              found,
  output logic [1:0]        ch
);

  // Walk the search order backwards so the channel closest to ptr wins.
  always_comb begin
    found = |req;
    ch    = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) ch = ptr + 2'(k);
    end
  end

endmodule

// File: rtl/rr_sel_gen4.sv
// Round-robin select generator with per-channel burst limit, driving the
// mux select through a registered valid/ready output stage.
module rr_sel_gen4
  import mux_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        sel,
  output logic [NUM_CH-1:0] gnt
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  state_t            state, state_n;
  logic [1:0]        cur, cur_n;
  logic [1:0]        ptr, ptr_n;
  logic [CW-1:0]     burst_cnt, burst_n;
  logic              valid_n;
  logic [1:0]        sel_n;
  logic [NUM_CH-1:0] gnt_n;

  logic [1:0]        pick_ptr;
  logic              pick_found;
  logic [1:0]        pick_ch;
  logic              others_req;

  // In GRANT the picker only matters on rotation, which always restarts at cur+1.
  assign pick_ptr   = (state == GRANT) ? (cur + 2'd1) : ptr;
  assign others_req = |(req & ~(NUM_CH'(1) << cur));

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .ch    (pick_ch)
  );

  // State register and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= 2'd0;
      ptr       <= 2'd0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      sel       <= 2'b00;
      gnt       <= '0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      burst_cnt <= burst_n;
      out_valid <= valid_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
    end
  end

  // Next-state logic: grant from IDLE, stay/rotate/drop on a transfer, hold on a stall.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    burst_n = burst_cnt;
    valid_n = out_valid;
    sel_n   = sel;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          cur_n   = pick_ch;
          gnt_n   = NUM_CH'(1) << pick_ch;
          sel_n   = ch2sel(pick_ch);
          valid_n = 1'b1;
          burst_n = CW'(1);
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (req[cur] && ((burst_cnt < BMAX) || !others_req)) begin
            if (burst_cnt < BMAX) burst_n = burst_cnt + CW'(1);
          end else begin
            ptr_n = cur + 2'd1;
            if (pick_found) begin
              cur_n   = pick_ch;
              gnt_n   = NUM_CH'(1) << pick_ch;
              sel_n   = ch2sel(pick_ch);
              burst_n = CW'(1);
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              gnt_n   = '0;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_sel_gen4.sv
// Scoreboard bench for rr_sel_gen4: a behavioural arbiter model predicts the
// outputs after every clock edge, a monitor compares them half a cycle later.
module tb_rr_sel_gen4;

  localparam int BM = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] sel;
  logic [3:0] gnt;

  rr_sel_gen4 #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    int       sel_code;
    int       gnt_mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   running = 1'b1;

  // Model state in plain integers.
  bit m_busy   = 0;
  int m_owner  = 0;
  int m_start  = 0;
  int m_streak = 0;
  int m_sel    = 0;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int others_count(input logic [3:0] r, input int owner);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (i != owner && r[i]) n++;
    return n;
  endfunction

  // Reference model: advance one edge using the inputs that the DUT also sees.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_start = 0; m_streak = 0; m_sel = 0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_owner  = pick(req, m_start);
        m_busy   = 1;
        m_streak = 1;
        m_sel    = 3 - m_owner;
      end
    end else if (out_ready) begin
      if (req[m_owner] && (m_streak < BM || others_count(req, m_owner) == 0)) begin
        m_streak = (m_streak + 1 > BM) ? BM : m_streak + 1;
      end else begin
        m_start = (m_owner + 1) % 4;
        if (req != 4'b0000) begin
          m_owner  = pick(req, m_start);
          m_streak = 1;
          m_sel    = 3 - m_owner;
        end else begin
          m_busy = 0;
        end
      end
    end
    e.valid    = m_busy;
    e.sel_code = m_sel;
    e.gnt_mask = m_busy ? (1 << m_owner) : 0;
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a registered output, check it.
  always @(negedge clk) begin
    if (running) begin
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expected entry at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== e.valid) begin
          n_fail++;
          $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, e.valid);
        end
        n_tests++;
        if (sel !== 2'(e.sel_code)) begin
          n_fail++;
          $display("FAIL sel @%0t: got %b want %b", $time, sel, 2'(e.sel_code));
        end
        n_tests++;
        if (gnt !== 4'(e.gnt_mask)) begin
          n_fail++;
          $display("FAIL gnt @%0t: got %b want %b", $time, gnt, 4'(e.gnt_mask));
        end
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic rdy, input logic rs, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      req       = r;
      out_ready = rdy;
      rst       = rs;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    #1;
    // Reset values with all requesting, then first grant is ch0.
    drive(4'b1111, 1'b1, 1'b1, 2);
    drive(4'b1111, 1'b1, 1'b0, 3);
    // Single requester beyond the burst limit.
    drive(4'b0100, 1'b1, 1'b1, 1);
    drive(4'b0100, 1'b1, 1'b0, 12);
    // Rotation at the burst limit across all four channels.
    drive(4'b1111, 1'b1, 1'b1, 1);
    drive(4'b1111, 1'b1, 1'b0, 20);
    // Stall mid-burst on ch2 with req[2] dropping, then rotate.
    drive(4'b0100, 1'b1, 1'b1, 1);
    drive(4'b0100, 1'b1, 1'b0, 2);
    drive(4'b0000, 1'b0, 1'b0, 5);
    drive(4'b1010, 1'b1, 1'b0, 3);
    // Stall then drop to IDLE.
    drive(4'b0100, 1'b1, 1'b1, 1);
    drive(4'b0100, 1'b1, 1'b0, 2);
    drive(4'b0000, 1'b0, 1'b0, 5);
    drive(4'b0000, 1'b1, 1'b0, 3);
    // Wrap-around from ch3 to ch0.
    drive(4'b1000, 1'b1, 1'b1, 1);
    drive(4'b1000, 1'b1, 1'b0, 2);
    drive(4'b1001, 1'b1, 1'b0, 6);
    // Reset mid-burst on ch1, then first grant ch0.
    drive(4'b0010, 1'b1, 1'b1, 1);
    drive(4'b0010, 1'b1, 1'b0, 2);
    drive(4'b0011, 1'b1, 1'b1, 1);
    drive(4'b0011, 1'b1, 1'b0, 3);
    // Randomised traffic with stalls and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(4'($urandom_range(0, 15)), ($urandom % 4) != 0, ($urandom % 64) == 0, 1);
    end
    drive(4'b0000, 1'b1, 1'b0, 2);
    @(negedge clk);
    #1;
    running = 1'b0;
    n_tests++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want at most 1", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
